rpp_fallback_resolver: RTL and testbench

Sequencer wrapped around rpp_canonical_top. It accepts a route request (primary address, target, fallback vector, threshold) over a valid/ready handshake and drives the canonical stage's address_in/address_valid. It consumes the canonical stage's registered results, and on a coherence failure re-issues the returned fallback_address, hop by hop, up to MAX_HOPS. It then returns one resolved address with a status code, hop count and score.

---
 rtl/rpp_fallback_resolver_pkg.sv | 24 ++
 rtl/rpp_fallback_resolver_best_candidate.sv | 48 ++++
 rtl/rpp_fallback_resolver.sv | 180 ++++++++++++++++++
 tb/tb_rpp_fallback_resolver.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpp_fallback_resolver_pkg.sv
// Shared types and widths for the fallback resolver: FSM states, response status codes,
// and the field widths used by the top and the best-candidate tracker.
package rpp_fallback_resolver_pkg;

  localparam int unsigned AddrW  = 32;
  localparam int unsigned ScoreW = 8;
  localparam int unsigned HopW   = 4;
  localparam int unsigned TmoW   = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    RspPrimary   = 2'd0,
    RspFallback  = 2'd1,
    RspExhausted = 2'd2,
    RspFault     = 2'd3
  } status_e;

endpackage

// File: rtl/rpp_fallback_resolver_best_candidate.sv
// Tracks the highest-scoring failed candidate of a request. The next-state values are exported
// so the resolver can report the post-update best in the same cycle a chain is exhausted.
module rpp_fallback_resolver_best_candidate
  import rpp_fallback_resolver_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic [AddrW-1:0]  i_clear_address,
  input  logic              i_offer,
  input  logic [AddrW-1:0]  i_address,
  input  logic [ScoreW-1:0] i_score,
  output logic [AddrW-1:0]  o_next_address,
  output logic [ScoreW-1:0] o_next_score
);

  logic [AddrW-1:0]  r_best_address;
  logic [ScoreW-1:0] r_best_score;
  logic [AddrW-1:0]  w_address_d;
  logic [ScoreW-1:0] w_score_d;

  // Strictly greater: on a tie the earlier candidate is kept.
  always_comb begin
    w_address_d = r_best_address;
    w_score_d   = r_best_score;
    if (i_clear) begin
      w_address_d = i_clear_address;
      w_score_d   = '0;
    end else if (i_offer && (i_score > r_best_score)) begin
      w_address_d = i_address;
      w_score_d   = i_score;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best_address <= '0;
      r_best_score   <= '0;
    end else begin
      r_best_address <= w_address_d;
      r_best_score   <= w_score_d;
    end
  end

  assign o_next_address = w_address_d;
  assign o_next_score   = w_score_d;

endmodule

// File: rtl/rpp_fallback_resolver.sv
// Sequencer around the canonical stage: issues the primary address, follows returned fallback
// addresses hop by hop, and reports one resolved address with status, hop count and score.
module rpp_fallback_resolver
  import rpp_fallback_resolver_pkg::*;
#(
  parameter int unsigned MAX_HOPS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AddrW-1:0]  req_address,
  input  logic [AddrW-1:0]  req_target,
  input  logic [7:0]        req_fallback_vector,
  input  logic [ScoreW-1:0] req_threshold,
  output logic [AddrW-1:0]  cn_address_in,
  output logic [AddrW-1:0]  cn_address_cmp,
  output logic [7:0]        cn_fallback_vector,
  output logic [ScoreW-1:0] cn_coherence_threshold,
  output logic              cn_address_valid,
  input  logic              cn_ready,
  input  logic              cn_valid,
  input  logic              cn_is_null,
  input  logic [ScoreW-1:0] cn_coherence_score,
  input  logic              cn_coherence_pass,
  input  logic [AddrW-1:0]  cn_fallback_address,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [AddrW-1:0]  rsp_address,
  output logic [1:0]        rsp_status,
  output logic [HopW-1:0]   rsp_hops,
  output logic [ScoreW-1:0] rsp_score
);

  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [HopW-1:0] HopMax  = HopW'(MAX_HOPS);

  state_e            r_state;
  logic [AddrW-1:0]  r_cand;
  logic [HopW-1:0]   r_hops;
  logic [TmoW-1:0]   r_tmo;
  logic              r_req_ready;
  logic [AddrW-1:0]  r_cn_address_in;
  logic [AddrW-1:0]  r_cn_address_cmp;
  logic [7:0]        r_cn_fallback_vector;
  logic [ScoreW-1:0] r_cn_threshold;
  logic              r_cn_address_valid;
  logic              r_rsp_valid;
  logic [AddrW-1:0]  r_rsp_address;
  status_e           r_rsp_status;
  logic [HopW-1:0]   r_rsp_hops;
  logic [ScoreW-1:0] r_rsp_score;

  logic              w_clear;
  logic              w_offer;
  logic              w_chain_end;
  logic [AddrW-1:0]  w_best_address;
  logic [ScoreW-1:0] w_best_score;

  assign w_clear     = (r_state == StIdle) && req_valid;
  assign w_offer     = (r_state == StWait) && cn_ready && cn_valid && !cn_is_null &&
                       !cn_coherence_pass;
  // A fallback pointing back at itself is a fixed point: following it cannot help.
  assign w_chain_end = (cn_fallback_address == r_cand) || (r_hops == HopMax);

  rpp_fallback_resolver_best_candidate u_best (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (w_clear),
    .i_clear_address (req_address),
    .i_offer         (w_offer),
    .i_address       (r_cand),
    .i_score         (cn_coherence_score),
    .o_next_address  (w_best_address),
    .o_next_score    (w_best_score)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state              <= StIdle;
      r_cand               <= '0;
      r_hops               <= '0;
      r_tmo                <= '0;
      r_req_ready          <= 1'b1;
      r_cn_address_in      <= '0;
      r_cn_address_cmp     <= '0;
      r_cn_fallback_vector <= '0;
      r_cn_threshold       <= '0;
      r_cn_address_valid   <= 1'b0;
      r_rsp_valid          <= 1'b0;
      r_rsp_address        <= '0;
      r_rsp_status         <= RspPrimary;
      r_rsp_hops           <= '0;
      r_rsp_score          <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_cn_address_cmp     <= req_target;
            r_cn_fallback_vector <= req_fallback_vector;
            r_cn_threshold       <= req_threshold;
            r_cand               <= req_address;
            r_cn_address_in      <= req_address;
            r_cn_address_valid   <= 1'b1;
            r_hops               <= '0;
            r_tmo                <= '0;
            r_req_ready          <= 1'b0;
            r_state              <= StIssue;
          end
        end
        StIssue: begin
          r_cn_address_valid <= 1'b0;
          r_tmo              <= '0;
          r_state            <= StWait;
        end
        StWait: begin
          if (cn_ready) begin
            r_rsp_hops <= r_hops;
            if (!cn_valid || cn_is_null) begin
              r_rsp_address <= r_cand;
              r_rsp_score   <= '0;
              r_rsp_status  <= RspFault;
              r_rsp_valid   <= 1'b1;
              r_state       <= StDone;
            end else if (cn_coherence_pass) begin
              r_rsp_address <= r_cand;
              r_rsp_score   <= cn_coherence_score;
              r_rsp_status  <= (r_hops == '0) ? RspPrimary : RspFallback;
              r_rsp_valid   <= 1'b1;
              r_state       <= StDone;
            end else if (w_chain_end) begin
              r_rsp_address <= w_best_address;
              r_rsp_score   <= w_best_score;
              r_rsp_status  <= RspExhausted;
              r_rsp_valid   <= 1'b1;
              r_state       <= StDone;
            end else begin
              r_cand             <= cn_fallback_address;
              r_cn_address_in    <= cn_fallback_address;
              r_cn_address_valid <= 1'b1;
              r_hops             <= r_hops + 4'd1;
              r_state            <= StIssue;
            end
          end else if (r_tmo == TmoLast) begin
            r_rsp_hops    <= r_hops;
            r_rsp_address <= r_cand;
            r_rsp_score   <= '0;
            r_rsp_status  <= RspFault;
            r_rsp_valid   <= 1'b1;
            r_state       <= StDone;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready              = r_req_ready;
  assign cn_address_in          = r_cn_address_in;
  assign cn_address_cmp         = r_cn_address_cmp;
  assign cn_fallback_vector     = r_cn_fallback_vector;
  assign cn_coherence_threshold = r_cn_threshold;
  assign cn_address_valid       = r_cn_address_valid;
  assign rsp_valid              = r_rsp_valid;
  assign rsp_address            = r_rsp_address;
  assign rsp_status             = r_rsp_status;
  assign rsp_hops               = r_rsp_hops;
  assign rsp_score              = r_rsp_score;

endmodule

// File: tb/tb_rpp_fallback_resolver.sv
// Randomized scoreboard bench: a canonical-stage stub replays planned per-hop results, a
// reference walk of the fallback chain predicts each response, and a monitor checks it.
module tb_rpp_fallback_resolver;

  localparam int MaxHops = 4;
  localparam int Tmo     = 8;
  localparam int Never   = 1000;

  typedef struct {
    bit          vld;
    bit          nul;
    bit          pas;
    logic [7:0]  score;
    logic [31:0] fb;
    int          dly;
  } cn_t;

  typedef struct {
    logic [31:0] addr;
    int          status;
    int          hops;
    logic [7:0]  score;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_address, req_target;
  logic [7:0]  req_fallback_vector, req_threshold;
  logic [31:0] cn_address_in, cn_address_cmp;
  logic [7:0]  cn_fallback_vector, cn_coherence_threshold;
  logic        cn_address_valid;
  logic        cn_ready, cn_valid, cn_is_null, cn_coherence_pass;
  logic [7:0]  cn_coherence_score;
  logic [31:0] cn_fallback_address;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_address;
  logic [1:0]  rsp_status;
  logic [3:0]  rsp_hops;
  logic [7:0]  rsp_score;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int force_hold = -1;
  logic [31:0] cur_tgt;
  logic [7:0]  cur_vec, cur_thr;

  cn_t         plan [MaxHops+1];
  bit          fix  [MaxHops+1];
  cn_t         stub_q[$];
  logic [31:0] cand_q[$];
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rpp_fallback_resolver #(.MAX_HOPS(MaxHops), .TIMEOUT_CYCLES(Tmo)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_address            (req_address),
    .req_target             (req_target),
    .req_fallback_vector    (req_fallback_vector),
    .req_threshold          (req_threshold),
    .cn_address_in          (cn_address_in),
    .cn_address_cmp         (cn_address_cmp),
    .cn_fallback_vector     (cn_fallback_vector),
    .cn_coherence_threshold (cn_coherence_threshold),
    .cn_address_valid       (cn_address_valid),
    .cn_ready               (cn_ready),
    .cn_valid               (cn_valid),
    .cn_is_null             (cn_is_null),
    .cn_coherence_score     (cn_coherence_score),
    .cn_coherence_pass      (cn_coherence_pass),
    .cn_fallback_address    (cn_fallback_address),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_address            (rsp_address),
    .rsp_status             (rsp_status),
    .rsp_hops               (rsp_hops),
    .rsp_score              (rsp_score)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic abort_run(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired at cycle %0d", name, cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic set_hop(input int i, input bit vld, input bit nul, input bit pas,
                         input logic [7:0] sc, input logic [31:0] fb, input bit fx,
                         input int dly);
    plan[i].vld   = vld;
    plan[i].nul   = nul;
    plan[i].pas   = pas;
    plan[i].score = sc;
    plan[i].fb    = fb;
    plan[i].dly   = dly;
    fix[i]        = fx;
  endtask

  task automatic rand_plan(input logic [7:0] thr);
    for (int i = 0; i <= MaxHops; i++) begin
      logic [7:0] sc;
      int d;
      // Half the scores come from a coarse set so ties between candidates occur.
      sc = ($urandom % 2 == 1) ? 8'($urandom_range(0, 255)) : 8'(100 + 50 * ($urandom % 4));
      d  = $urandom % 20;
      set_hop(i, ($urandom % 16) != 0, ($urandom % 16) == 0, sc >= thr, sc, $urandom,
              ($urandom % 6) == 0,
              (d < 12) ? 0 : (d < 15) ? 1 : (d < 17) ? 3 : (d < 19) ? 7 : Never);
    end
  endtask

  // Walk the chain by the resolution rules; queue what the stub replays and the response.
  task automatic model_push(input logic [31:0] addr);
    exp_t e;
    cn_t r;
    logic [31:0] cand, baddr;
    logic [7:0] best;
    int lat;
    bit done;
    cand = addr; baddr = addr; best = 8'd0; lat = 0; done = 1'b0;
    e.addr = 32'd0; e.status = 0; e.hops = 0; e.score = 8'd0; e.lat = 0;
    for (int i = 0; i <= MaxHops && !done; i++) begin
      r = plan[i];
      if (fix[i]) r.fb = cand;
      cand_q.push_back(cand);
      stub_q.push_back(r);
      e.hops = i;
      done = 1'b1;
      if (r.dly >= Tmo) begin
        lat += Tmo + 1;
        e.addr = cand; e.status = 3; e.score = 8'd0;
      end else begin
        lat += r.dly + 2;
        if (!r.vld || r.nul) begin
          e.addr = cand; e.status = 3; e.score = 8'd0;
        end else if (r.pas) begin
          e.addr = cand; e.status = (i == 0) ? 0 : 1; e.score = r.score;
        end else begin
          if (r.score > best) begin
            best = r.score; baddr = cand;
          end
          if (r.fb == cand || i == MaxHops) begin
            e.addr = baddr; e.status = 2; e.score = best;
          end else begin
            cand = r.fb;
            done = 1'b0;
          end
        end
      end
    end
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic accept(input logic [31:0] addr, input logic [31:0] tgt, input logic [7:0] vec,
                        input logic [7:0] thr);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (k == 100) abort_run("req_ready_wait");
    cur_tgt = tgt; cur_vec = vec; cur_thr = thr;
    req_address = addr; req_target = tgt; req_fallback_vector = vec; req_threshold = thr;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    req_address = $urandom; req_target = $urandom;
    req_fallback_vector = 8'($urandom); req_threshold = 8'($urandom);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && req_ready && !rsp_valid) break;
    end
    if (k == 400) abort_run("response_wait");
  endtask

  task automatic do_req(input logic [31:0] addr, input logic [31:0] tgt, input logic [7:0] vec,
                        input logic [7:0] thr);
    model_push(addr);
    accept(addr, tgt, vec, thr);
    wait_idle();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_cn_valid"}, 64'(cn_address_valid), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_cn_addr"}, {cn_address_in, cn_address_cmp}, 64'd0);
    chk({tag, "_cn_cfg"}, {cn_fallback_vector, cn_coherence_threshold}, 64'd0);
    chk({tag, "_rsp_data"}, {rsp_address, rsp_status, rsp_hops, rsp_score}, 64'd0);
  endtask

  // Canonical-stage stub: answers each issue strobe with the next planned result.
  initial begin
    cn_t r;
    logic [31:0] c;
    cn_ready = 1'b0; cn_valid = 1'b0; cn_is_null = 1'b0; cn_coherence_pass = 1'b0;
    cn_coherence_score = 8'd0; cn_fallback_address = 32'd0;
    forever begin
      @(negedge clk);
      if (cn_address_valid === 1'b1) begin
        if (cand_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue actual=%0h required=none", cn_address_in);
        end else begin
          c = cand_q.pop_front();
          r = stub_q.pop_front();
          chk("issue_addr", 64'(cn_address_in), 64'(c));
          chk("issue_cmp", 64'(cn_address_cmp), 64'(cur_tgt));
          chk("issue_cfg", {cn_fallback_vector, cn_coherence_threshold}, {cur_vec, cur_thr});
          @(posedge clk);
          #1;
          if (r.dly < Tmo) begin
            if (r.dly > 0) begin
              repeat (r.dly) @(posedge clk);
              #1;
            end
            cn_ready = 1'b1; cn_valid = r.vld; cn_is_null = r.nul;
            cn_coherence_pass = r.pas; cn_coherence_score = r.score;
            cn_fallback_address = r.fb;
            @(posedge clk);
            #1;
            cn_ready = 1'b0; cn_valid = 1'($urandom); cn_is_null = 1'($urandom);
            cn_coherence_pass = 1'($urandom); cn_coherence_score = 8'($urandom);
            cn_fallback_address = $urandom;
          end
        end
      end
    end
  end

  // Response monitor: scoreboard compare, random backpressure, stability while stalled.
  initial begin
    exp_t e;
    logic [45:0] snap;
    int hold;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        snap = {rsp_address, rsp_status, rsp_hops, rsp_score};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual=%0h required=none", snap);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_address", 64'(rsp_address), 64'(e.addr));
          chk("rsp_status", 64'(rsp_status), 64'(e.status));
          chk("rsp_hops", 64'(rsp_hops), 64'(e.hops));
          chk("rsp_score", 64'(rsp_score), 64'(e.score));
          chk("rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
          chk("req_ready_busy", 64'(req_ready), 64'd0);
        end
        hold = (force_hold >= 0) ? force_hold : $urandom_range(0, 3);
        force_hold = -1;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          chk("rsp_stable", {rsp_address, rsp_status, rsp_hops, rsp_score}, 64'(snap));
          chk("rsp_hold_flags", {rsp_valid, req_ready}, 64'b10);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_release_flags", {rsp_valid, req_ready}, 64'b01);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    req_valid = 1'b0; req_address = 32'd0; req_target = 32'd0;
    req_fallback_vector = 8'd0; req_threshold = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Primary hit.
    set_hop(0, 1, 0, 1, 8'd255, 32'h0, 0, 0);
    do_req(32'h2A30_0000, 32'h2A30_0000, 8'h00, 8'd200);
    // Primary fails at 249, first fallback passes; consumer stalls 5 cycles.
    set_hop(0, 1, 0, 0, 8'd249, 32'h3230_0000, 0, 0);
    set_hop(1, 1, 0, 1, 8'd255, 32'h0, 0, 0);
    force_hold = 5;
    do_req(32'h2A30_0000, 32'h3230_0000, 8'h20, 8'd255);
    // Fallback equals candidate: exhausted at hop 0 with the primary's own score.
    set_hop(0, 1, 0, 0, 8'd180, 32'h0, 1, 0);
    do_req(32'h2A30_0000, 32'hD880_0000, 8'h00, 8'd255);
    // Invalid and null candidates fault.
    set_hop(0, 0, 0, 0, 8'd77, 32'h0, 0, 0);
    do_req(32'h0000_0000, 32'h2A30_0000, 8'h00, 8'd200);
    set_hop(0, 1, 1, 1, 8'd255, 32'h0, 0, 1);
    do_req(32'h1111_0000, 32'h2A30_0000, 8'h00, 8'd200);
    // Silent canonical stage: timeout fault; then a result one cycle short of the timeout.
    set_hop(0, 1, 0, 1, 8'd255, 32'h0, 0, Never);
    do_req(32'h2A30_0000, 32'h2A30_0000, 8'h00, 8'd200);
    set_hop(0, 1, 0, 1, 8'd222, 32'h0, 0, Tmo - 1);
    do_req(32'h2A30_0000, 32'h2A30_0000, 8'h00, 8'd200);
    // Full chain that never passes: best is the earliest of the tied 200s.
    set_hop(0, 1, 0, 0, 8'd120, 32'h1000_0000, 0, 0);
    set_hop(1, 1, 0, 0, 8'd200, 32'h2000_0000, 0, 1);
    set_hop(2, 1, 0, 0, 8'd150, 32'h3000_0000, 0, 0);
    set_hop(3, 1, 0, 0, 8'd200, 32'h4000_0000, 0, 2);
    set_hop(4, 1, 0, 0, 8'd90,  32'h5000_0000, 0, 0);
    do_req(32'h0A00_0000, 32'h0B00_0000, 8'h44, 8'd250);

    for (int n = 0; n < 150; n++) begin
      logic [7:0] thr;
      thr = 8'($urandom_range(150, 255));
      rand_plan(thr);
      do_req($urandom, $urandom, 8'($urandom), thr);
    end

    // Reset while waiting on the canonical stage aborts the request silently.
    set_hop(0, 1, 0, 1, 8'd255, 32'h0, 0, Never);
    cand_q.push_back(32'h1234_5000);
    stub_q.push_back(plan[0]);
    accept(32'h1234_5000, 32'h1234_5000, 8'h11, 8'd100);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("midreq_reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", 64'(seen), 64'd0);

    set_hop(0, 1, 0, 1, 8'd201, 32'h0, 0, 0);
    do_req(32'h2A30_0000, 32'h2A30_0000, 8'h00, 8'd200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
